// File: rtl/quad_velocity.sv
// quad_velocity: per-window signed velocity, moving average and stall
// detection from a free-running 32-bit quadrature position count.
module quad_velocity #(
   parameter int TICK_DIV      = 1000000,
   parameter int AVG_LOG2      = 2,
   parameter int VEL_W         = 16,
   parameter int STALL_WINDOWS = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      count,
   input  logic             enable,
   input  logic             motor_on,
   input  logic             clear_stall,
   output logic [VEL_W-1:0] velocity,
   output logic [VEL_W-1:0] velocity_avg,
   output logic             sample_valid,
   output logic             stalled,
   output logic             sat_sticky
);

   localparam int PW    = $clog2(TICK_DIV);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SW    = VEL_W + AVG_LOG2;
   localparam int CW    = $clog2(STALL_WINDOWS + 1);

   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ST_MAX  = CW'(STALL_WINDOWS);

   localparam logic signed [31:0] V_MAX =
      (32'sd1 <<< (VEL_W - 1)) - 32'sd1;
   localparam logic signed [31:0] V_MIN = ~V_MAX;

   logic [PW-1:0]           presc_q, presc_d;
   logic                    primed_q, primed_d;
   logic [31:0]             prev_q, prev_d;
   logic signed [31:0]      delta_q, delta_d;
   logic                    v1_q, v1_d;
   logic                    v2_q, v2_d;
   logic [VEL_W-1:0]        clamp_q, clamp_d;
   logic [VEL_W-1:0]        buf_q [DEPTH];
   logic [VEL_W-1:0]        buf_d [DEPTH];
   logic [AVG_LOG2-1:0]     wptr_q, wptr_d;
   logic signed [SW-1:0]    sum_q, sum_d;
   logic [VEL_W-1:0]        vel_q, vel_d;
   logic [VEL_W-1:0]        avg_q, avg_d;
   logic                    sv_q, sv_d;
   logic                    stl_q, stl_d;
   logic                    sat_q, sat_d;
   logic [CW-1:0]           scnt_q, scnt_d;

   logic                    tick;
   logic                    wr;
   logic                    strobe;
   logic [VEL_W-1:0]        clamp_now;
   logic                    sat_now;
   logic [VEL_W-1:0]        oldest;

   assign tick   = enable && (presc_q == PS_LAST);
   assign wr     = v1_q && enable;
   assign strobe = v2_q && enable;
   assign oldest = buf_q[wptr_q];

   // Window prescaler and sampling; the first tick only primes prev.
   always_comb begin
      presc_d  = presc_q;
      primed_d = primed_q;
      prev_d   = prev_q;
      delta_d  = delta_q;
      v1_d     = 1'b0;
      if (!enable) begin
         presc_d  = '0;
         primed_d = 1'b0;
      end else if (tick) begin
         presc_d  = '0;
         primed_d = 1'b1;
         prev_d   = count;
         if (primed_q) begin
            delta_d = $signed(count - prev_q);
            v1_d    = 1'b1;
         end
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_comb begin
      sat_now = 1'b1;
      if (delta_q > V_MAX) begin
         clamp_now = V_MAX[VEL_W-1:0];
      end else if (delta_q < V_MIN) begin
         clamp_now = V_MIN[VEL_W-1:0];
      end else begin
         clamp_now = delta_q[VEL_W-1:0];
         sat_now   = 1'b0;
      end
   end

   // Ring buffer replaces the oldest entry; sum tracks the window.
   always_comb begin
      buf_d   = buf_q;
      wptr_d  = wptr_q;
      sum_d   = sum_q;
      clamp_d = clamp_q;
      sat_d   = sat_q;
      v2_d    = wr;
      if (wr) begin
         buf_d[wptr_q] = clamp_now;
         wptr_d  = wptr_q + 1'b1;
         sum_d   = sum_q
                 + {{AVG_LOG2{clamp_now[VEL_W-1]}}, clamp_now}
                 - {{AVG_LOG2{oldest[VEL_W-1]}}, oldest};
         clamp_d = clamp_now;
         sat_d   = sat_q | sat_now;
      end
   end

   always_comb begin
      vel_d = vel_q;
      avg_d = avg_q;
      sv_d  = strobe;
      if (strobe) begin
         vel_d = clamp_q;
         avg_d = VEL_W'(sum_q >>> AVG_LOG2);
      end
   end

   always_comb begin
      scnt_d = scnt_q;
      stl_d  = stl_q;
      if (clear_stall) begin
         scnt_d = '0;
         stl_d  = 1'b0;
      end else if (strobe) begin
         if (clamp_q == '0 && motor_on) begin
            if (scnt_q != ST_MAX) scnt_d = scnt_q + 1'b1;
            if (scnt_d == ST_MAX) stl_d = 1'b1;
         end else begin
            scnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q  <= '0;
         primed_q <= 1'b0;
         prev_q   <= '0;
         delta_q  <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         clamp_q  <= '0;
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
         wptr_q   <= '0;
         sum_q    <= '0;
         vel_q    <= '0;
         avg_q    <= '0;
         sv_q     <= 1'b0;
         stl_q    <= 1'b0;
         sat_q    <= 1'b0;
         scnt_q   <= '0;
      end else begin
         presc_q  <= presc_d;
         primed_q <= primed_d;
         prev_q   <= prev_d;
         delta_q  <= delta_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         clamp_q  <= clamp_d;
         buf_q    <= buf_d;
         wptr_q   <= wptr_d;
         sum_q    <= sum_d;
         vel_q    <= vel_d;
         avg_q    <= avg_d;
         sv_q     <= sv_d;
         stl_q    <= stl_d;
         sat_q    <= sat_d;
         scnt_q   <= scnt_d;
      end
   end

   assign velocity     = vel_q;
   assign velocity_avg = avg_q;
   assign sample_valid = sv_q;
   assign stalled      = stl_q;
   assign sat_sticky   = sat_q;

endmodule

// File: doc/quad_velocity.md
Name: quad_velocity

Overview:
Downstream consumer of the quadrature decoder's 32-bit position count. Samples the count once per fixed window of clock cycles and produces three results: a saturated signed per-window delta (velocity), a power-of-two moving average of that delta, and a stall flag. Feeds the robot's motor speed loop and its fault logic.

Parameters:
TICK_DIV, 1000000, clocks per sample window (>=4)
AVG_LOG2, 2, moving average depth = 2^AVG_LOG2 samples (1..4)
VEL_W, 16, signed width of velocity outputs (8..32)
STALL_WINDOWS, 8, consecutive zero-delta windows with motor_on that raise stalled (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
count  in  32  position count from quadrature decoder, free-running, wraps mod 2^32
enable  in  1  measurement enable
motor_on  in  1  motor drive commanded; qualifies stall detection
clear_stall  in  1  single-cycle pulse, clears stalled
velocity  out  VEL_W  signed saturated delta of last window
velocity_avg  out  VEL_W  signed moving average of last 2^AVG_LOG2 deltas
sample_valid  out  1  one-cycle strobe, new velocity/velocity_avg
stalled  out  1  sticky stall flag
sat_sticky  out  1  sticky, set when any delta saturated; cleared only by reset

Behaviour:
- Reset (async, resetn=0): all outputs 0; prescaler, prev_count, primed, ring buffer, running sum, stall counter all 0.
- Prescaler: while enable=1, counts 0..TICK_DIV-1 and wraps. The tick occurs on the edge where the prescaler is at TICK_DIV-1; count is sampled on that edge. First tick occurs TICK_DIV clocks after enable rises.
- enable=0: prescaler held at 0, primed cleared, no ticks. Outputs, buffer and stall counter hold. sample_valid=0.
- Priming: the first tick after reset or after enable rises only latches prev_count and sets primed. It produces no sample_valid.
- Primed tick, cycle T: delta = (count - prev_count) mod 2^32, interpreted as signed 32-bit, so counter wrap is handled. Then prev_count <= count.
- T+1: delta clamped to [-2^(VEL_W-1), 2^(VEL_W-1)-1]. If clamping occurred, sat_sticky is set. Clamped value is written to the ring buffer at the write pointer, overwriting the oldest entry. Running sum <= sum + new - oldest. Sum width is VEL_W+AVG_LOG2, so it cannot overflow.
- T+2: velocity <= clamped delta; velocity_avg <= sum >>> AVG_LOG2 (arithmetic, floor toward -inf); sample_valid=1 for this cycle only. Latency from sampling edge to strobe is 2 clocks.
- Fill: the buffer starts at zero. The first 2^AVG_LOG2-1 averages include zero entries; there is no separate fill indication.
- Stall detection, evaluated at each sample_valid:
  - clamped delta==0 and motor_on=1: stall counter increments, saturating at STALL_WINDOWS.
  - Otherwise: stall counter clears.
  - When the counter reaches STALL_WINDOWS, stalled=1 in the same cycle as sample_valid. stalled is sticky.
- clear_stall: clears stalled and the stall counter. If it coincides with a set condition, clear wins.
- Reset mid-window: everything returns to reset state. After release, the next tick primes again.

Test Plan:
Bench parameters: TICK_DIV=10, AVG_LOG2=2, VEL_W=8, STALL_WINDOWS=3.
- Constant motion: count starts at 0x8000 and increases by 5 per window -> first tick primes with no strobe. Following strobes give velocity=5 each time and velocity_avg=1,2,3,5,5. Strobes are 10 clocks apart, each 2 clocks after its sampling edge.
- Counter wrap: count goes 0xFFFFFFFE then 0x00000003 on consecutive ticks -> velocity=+5, sat_sticky=0.
- Saturation: delta +300 -> velocity=127, sat_sticky=1. Then delta -300 -> velocity=-128, sat_sticky stays 1.
- Negative average: from reset, delta -3 every window -> velocity_avg=-1,-2,-3,-3.
- Stall: motor_on=1, count constant -> stalled=1 on the 3rd strobe. clear_stall pulsed on the cycle of the 4th strobe -> stalled=0, counter 0. With motor_on=0 and count constant, stalled never sets.
- Reset/enable mid-run: resetn low mid-window -> all outputs 0 immediately, without waiting for a clock. After release, the first tick primes and the first strobe comes one window later. Dropping enable holds outputs; re-raising it re-primes.
